// File: rtl/adc_threshold_discriminator.sv
// Hysteresis-gated segment extractor for one ADC channel. Forwards batches
// that fall inside an activity segment, framed with tlast, plus one
// batch-index timestamp per segment start.
// Ports: s_axis_* input batches (never backpressured), m_axis_data_*
// forwarded batches, m_axis_tstamp_* segment-start index, cfg_* register
// map inputs, overflow sticky drop flag.
module adc_threshold_discriminator #(
  parameter int PARALLEL_SAMPLES = 16,
  parameter int SAMPLE_WIDTH     = 16,
  parameter int TIMESTAMP_WIDTH  = 48
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [PARALLEL_SAMPLES*SAMPLE_WIDTH-1:0] s_axis_tdata,
  input  logic                                     s_axis_tvalid,
  output logic                                     s_axis_tready,
  output logic [PARALLEL_SAMPLES*SAMPLE_WIDTH-1:0] m_axis_data_tdata,
  output logic                                     m_axis_data_tvalid,
  output logic                                     m_axis_data_tlast,
  input  logic                                     m_axis_data_tready,
  output logic [TIMESTAMP_WIDTH-1:0]               m_axis_tstamp_tdata,
  output logic                                     m_axis_tstamp_tvalid,
  input  logic                                     m_axis_tstamp_tready,
  input  logic                                     cfg_enable,
  input  logic [SAMPLE_WIDTH-1:0]                  cfg_threshold_high,
  input  logic [SAMPLE_WIDTH-1:0]                  cfg_threshold_low,
  input  logic                                     cfg_clear_overflow,
  output logic                                     overflow
);

  localparam int DW = PARALLEL_SAMPLES * SAMPLE_WIDTH;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                           accept;
  logic [TIMESTAMP_WIDTH-1:0]     batch_idx;
  logic signed [SAMPLE_WIDTH-1:0] smp;
  logic signed [SAMPLE_WIDTH-1:0] thr_hi;
  logic signed [SAMPLE_WIDTH-1:0] thr_lo;
  logic                           hi;
  logic                           lo;

  logic                       s1_valid;
  logic                       s1_hi;
  logic                       s1_lo;
  logic                       s1_en;
  logic [DW-1:0]              s1_data;
  logic [TIMESTAMP_WIDTH-1:0] s1_idx;

  logic emit;
  logic emit_last;
  logic emit_ts;
  logic data_free;
  logic ts_free;
  logic drop;

  assign accept = s_axis_tvalid & s_axis_tready;
  assign thr_hi = cfg_threshold_high;
  assign thr_lo = cfg_threshold_low;

  always_ff @(posedge clk) begin
    if (reset) begin
      s_axis_tready <= 1'b0;
      batch_idx     <= '0;
    end else begin
      s_axis_tready <= 1'b1;
      if (accept) batch_idx <= batch_idx + TIMESTAMP_WIDTH'(1);
    end
  end

  // hi: any sample above the trigger level; lo: all samples below release
  always_comb begin
    hi  = 1'b0;
    lo  = 1'b1;
    smp = '0;
    for (int i = 0; i < PARALLEL_SAMPLES; i++) begin
      smp = s_axis_tdata[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      if (smp > thr_hi) hi = 1'b1;
      if (!(smp < thr_lo)) lo = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_hi    <= 1'b0;
      s1_lo    <= 1'b0;
      s1_en    <= 1'b0;
      s1_data  <= '0;
      s1_idx   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_hi   <= hi;
        s1_lo   <= lo;
        s1_en   <= cfg_enable;
        s1_data <= s_axis_tdata;
        s1_idx  <= batch_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    emit_last = 1'b0;
    emit_ts   = 1'b0;
    if (s1_valid) begin
      unique case (state)
        IDLE: begin
          if (s1_en && s1_hi) begin
            emit    = 1'b1;
            emit_ts = 1'b1;
            // a trigger batch that is also quiet is a one-beat segment
            if (s1_lo) emit_last = 1'b1;
            else       state_nxt = ACTIVE;
          end
        end
        ACTIVE: begin
          emit = 1'b1;
          if (s1_lo || !s1_en) begin
            emit_last = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // a register is free when empty or when its beat transfers this cycle
  assign data_free = ~m_axis_data_tvalid | m_axis_data_tready;
  assign ts_free   = ~m_axis_tstamp_tvalid | m_axis_tstamp_tready;
  assign drop      = (emit & ~data_free) | (emit_ts & ~ts_free);

  always_ff @(posedge clk) begin
    if (reset) begin
      m_axis_data_tvalid <= 1'b0;
      m_axis_data_tlast  <= 1'b0;
      m_axis_data_tdata  <= '0;
    end else if (emit && data_free) begin
      m_axis_data_tvalid <= 1'b1;
      m_axis_data_tlast  <= emit_last;
      m_axis_data_tdata  <= s1_data;
    end else if (m_axis_data_tready) begin
      m_axis_data_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_axis_tstamp_tvalid <= 1'b0;
      m_axis_tstamp_tdata  <= '0;
    end else if (emit_ts && ts_free) begin
      m_axis_tstamp_tvalid <= 1'b1;
      m_axis_tstamp_tdata  <= s1_idx;
    end else if (m_axis_tstamp_tready) begin
      m_axis_tstamp_tvalid <= 1'b0;
    end
  end

  // set beats clear when both land in the same cycle
  always_ff @(posedge clk) begin
    if (reset)                   overflow <= 1'b0;
    else if (drop)               overflow <= 1'b1;
    else if (cfg_clear_overflow) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_adc_threshold_discriminator.sv
// Testbench for adc_threshold_discriminator: directed scenarios plus
// randomized streams against a segment-level reference model.
module tb_adc_threshold_discriminator;

  localparam int N  = 16;
  localparam int SW = 16;
  localparam int TW = 48;
  localparam int NW = 4;
  localparam int DW = N * SW;

  logic clk = 1'b0;
  always #2 clk = ~clk;

  logic          reset;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic          d_ready;
  logic          t_ready;
  logic          en;
  logic          clr;
  logic [SW-1:0] thr_hi;
  logic [SW-1:0] thr_lo;

  logic [DW-1:0] m_d_data;
  logic          m_d_valid;
  logic          m_d_last;
  logic [TW-1:0] m_t_data;
  logic          m_t_valid;
  logic          ovf;

  logic          n_s_tready;
  logic [DW-1:0] n_d_data;
  logic          n_d_valid;
  logic          n_d_last;
  logic [NW-1:0] n_t_data;
  logic          n_t_valid;
  logic          n_ovf;

  adc_threshold_discriminator #(
    .PARALLEL_SAMPLES(N), .SAMPLE_WIDTH(SW), .TIMESTAMP_WIDTH(TW)
  ) dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .m_axis_data_tdata(m_d_data), .m_axis_data_tvalid(m_d_valid),
    .m_axis_data_tlast(m_d_last), .m_axis_data_tready(d_ready),
    .m_axis_tstamp_tdata(m_t_data), .m_axis_tstamp_tvalid(m_t_valid),
    .m_axis_tstamp_tready(t_ready),
    .cfg_enable(en), .cfg_threshold_high(thr_hi),
    .cfg_threshold_low(thr_lo), .cfg_clear_overflow(clr),
    .overflow(ovf)
  );

  adc_threshold_discriminator #(
    .PARALLEL_SAMPLES(N), .SAMPLE_WIDTH(SW), .TIMESTAMP_WIDTH(NW)
  ) dut_n (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(n_s_tready),
    .m_axis_data_tdata(n_d_data), .m_axis_data_tvalid(n_d_valid),
    .m_axis_data_tlast(n_d_last), .m_axis_data_tready(d_ready),
    .m_axis_tstamp_tdata(n_t_data), .m_axis_tstamp_tvalid(n_t_valid),
    .m_axis_tstamp_tready(t_ready),
    .cfg_enable(en), .cfg_threshold_high(thr_hi),
    .cfg_threshold_low(thr_lo), .cfg_clear_overflow(clr),
    .overflow(n_ovf)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         exp_d[$];
  beat_t         got_d[$];
  logic [TW-1:0] exp_t[$];
  logic [TW-1:0] got_t[$];
  logic [NW-1:0] got_tn[$];

  int tests = 0;
  int fails = 0;

  bit            m_seg;
  logic [TW-1:0] m_idx;

  always @(negedge clk) begin
    beat_t b;
    if (!reset) begin
      if (m_d_valid && d_ready) begin
        b.data = m_d_data;
        b.last = m_d_last;
        got_d.push_back(b);
      end
      if (m_t_valid && t_ready) got_t.push_back(m_t_data);
      if (n_t_valid && t_ready) got_tn.push_back(n_t_data);
    end
  end

  function automatic logic [DW-1:0] mk(input int v);
    logic [DW-1:0] d;
    for (int i = 0; i < N; i++) d[i*SW +: SW] = v[15:0];
    return d;
  endfunction

  function automatic logic [DW-1:0] put(input logic [DW-1:0] d,
                                        input int i, input int v);
    logic [DW-1:0] r;
    r = d;
    r[i*SW +: SW] = v[15:0];
    return r;
  endfunction

  // segment rules applied per accepted batch, assuming no drops
  function automatic void model(input logic [DW-1:0] d);
    logic signed [15:0] sv;
    logic signed [15:0] th;
    logic signed [15:0] tl;
    int    s;
    int    h;
    int    l;
    bit    hi;
    bit    lo;
    beat_t b;
    th = thr_hi;
    tl = thr_lo;
    h  = th;
    l  = tl;
    hi = 1'b0;
    lo = 1'b1;
    for (int i = 0; i < N; i++) begin
      sv = d[i*SW +: SW];
      s  = sv;
      if (s > h) hi = 1'b1;
      if (s >= l) lo = 1'b0;
    end
    b.data = d;
    if (!m_seg) begin
      if (en && hi) begin
        exp_t.push_back(m_idx);
        b.last = lo;
        exp_d.push_back(b);
        m_seg = !lo;
      end
    end else begin
      b.last = lo || !en;
      exp_d.push_back(b);
      if (b.last) m_seg = 1'b0;
    end
    m_idx = m_idx + 1;
  endfunction

  task automatic send(input logic [DW-1:0] d, input bit v);
    s_tdata  = d;
    s_tvalid = v;
    if (v) model(d);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    s_tvalid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    exp_d.delete();
    got_d.delete();
    exp_t.delete();
    got_t.delete();
    got_tn.delete();
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    clr      = 1'b0;
    d_ready  = 1'b1;
    t_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    m_seg = 1'b0;
    m_idx = '0;
    clear_q();
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    clr      = 1'b0;
    d_ready  = 1'b1;
    t_ready  = 1'b1;
    en       = 1'b1;
    thr_hi   = 16'd1000;
    thr_lo   = 16'd200;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({s_tready, m_d_valid, m_d_last, m_t_valid, ovf, n_t_valid}
        !== 6'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b want 000000",
               {s_tready, m_d_valid, m_d_last, m_t_valid, ovf, n_t_valid});
    end
    tests++;
    if (m_d_data !== '0 || m_t_data !== '0) begin
      fails++;
      $display("FAIL reset_data: got %0h/%0h want 0/0",
               m_d_data, m_t_data);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (s_tready !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_reset: got %b want 1", s_tready);
    end
    m_seg = 1'b0;
    m_idx = '0;
    clear_q();
  endtask

  task automatic test_basic();
    logic [DW-1:0] trig;
    logic [DW-1:0] want[4];
    do_reset();
    en     = 1'b1;
    thr_hi = 16'd1000;
    thr_lo = 16'd200;
    trig   = put(mk(0), 3, 1001);
    want[0] = trig;
    want[1] = mk(500);
    want[2] = mk(500);
    want[3] = mk(100);
    for (int i = 0; i < 5; i++) send(mk(0), 1'b1);
    send(trig, 1'b1);
    tests++;
    if (m_d_valid !== 1'b0) begin
      fails++;
      $display("FAIL latency_early: got valid %b want 0", m_d_valid);
    end
    send(mk(500), 1'b1);
    tests++;
    if (m_d_valid !== 1'b1 || m_d_data !== trig) begin
      fails++;
      $display("FAIL latency_2cyc: got valid %b data %0h want 1 %0h",
               m_d_valid, m_d_data, trig);
    end
    send(mk(500), 1'b1);
    send(mk(100), 1'b1);
    drain();
    tests++;
    if (got_d.size() != 4) begin
      fails++;
      $display("FAIL basic_count: got %0d want 4", got_d.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (got_d[i].data !== want[i] || got_d[i].last !== (i == 3)) begin
          fails++;
          $display("FAIL basic_beat%0d: got last %b want %b", i,
                   got_d[i].last, (i == 3));
        end
      end
    end
    tests++;
    if (got_t.size() != 1 || got_t[0] !== 48'd5) begin
      fails++;
      $display("FAIL basic_tstamp: got n=%0d want one ts=5",
               got_t.size());
    end
  endtask

  task automatic test_signed();
    do_reset();
    en     = 1'b1;
    thr_hi = 16'd1000;
    thr_lo = 16'h8000;
    send(put(mk(0), 7, 1000), 1'b1);
    thr_hi = 16'h8000;
    send(mk(-32768), 1'b1);
    drain();
    tests++;
    if (got_d.size() != 0 || got_t.size() != 0) begin
      fails++;
      $display("FAIL equal_no_trigger: got %0d beats want 0",
               got_d.size());
    end
    send(put(mk(-32768), 0, -32767), 1'b1);
    thr_lo = 16'h8001;
    send(mk(-32768), 1'b1);
    drain();
    tests++;
    if (got_t.size() != 1 || got_t[0] !== 48'd2) begin
      fails++;
      $display("FAIL signed_trigger_ts: got n=%0d want one ts=2",
               got_t.size());
    end
    tests++;
    if (got_d.size() != 2 || got_d[0].last !== 1'b0
        || got_d[1].last !== 1'b1) begin
      fails++;
      $display("FAIL signed_segment: got %0d beats want 2 last=01",
               got_d.size());
    end
  endtask

  task automatic test_single();
    logic [DW-1:0] b;
    do_reset();
    en     = 1'b1;
    thr_hi = 16'd1000;
    thr_lo = 16'd2000;
    b      = put(mk(0), 9, 1500);
    send(b, 1'b1);
    send(mk(0), 1'b1);
    send(mk(0), 1'b1);
    drain();
    tests++;
    if (got_d.size() != 1 || got_d[0].data !== b
        || got_d[0].last !== 1'b1) begin
      fails++;
      $display("FAIL single_beat: got %0d beats want 1 with tlast",
               got_d.size());
    end
    tests++;
    if (got_t.size() != 1 || got_t[0] !== 48'd0) begin
      fails++;
      $display("FAIL single_ts: got n=%0d want one ts=0", got_t.size());
    end
  endtask

  task automatic test_enable_drop();
    logic [DW-1:0] trig;
    do_reset();
    en     = 1'b1;
    thr_hi = 16'd1000;
    thr_lo = 16'd200;
    trig   = put(mk(0), 15, 2000);
    for (int i = 0; i < 10; i++) send(mk(0), 1'b1);
    send(trig, 1'b1);
    send(mk(500), 1'b1);
    en = 1'b0;
    send(mk(500), 1'b1);
    send(trig, 1'b1);
    send(mk(500), 1'b1);
    drain();
    tests++;
    if (got_d.size() != 3 || got_d[2].last !== 1'b1
        || got_d[1].last !== 1'b0 || got_d[2].data !== mk(500)) begin
      fails++;
      $display("FAIL enable_drop_close: got %0d beats want 3 ending tlast",
               got_d.size());
    end
    tests++;
    if (got_t.size() != 1 || got_t[0] !== 48'd10) begin
      fails++;
      $display("FAIL enable_drop_ts: got n=%0d want one ts=10",
               got_t.size());
    end
    en = 1'b1;
    send(trig, 1'b1);
    send(mk(100), 1'b1);
    drain();
    tests++;
    if (got_t.size() != 2 || got_d.size() != 5
        || got_t[got_t.size()-1] !== 48'd15) begin
      fails++;
      $display("FAIL retrigger: got %0d ts %0d beats want 2 ts 5 beats",
               got_t.size(), got_d.size());
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] trig;
    logic [DW-1:0] b;
    do_reset();
    en      = 1'b1;
    thr_hi  = 16'd1000;
    thr_lo  = 16'd200;
    trig    = put(mk(0), 4, 1001);
    d_ready = 1'b0;
    send(trig, 1'b1);
    send(mk(500), 1'b1);
    send(mk(500), 1'b1);
    send(mk(100), 1'b1);
    drain();
    tests++;
    if (m_d_valid !== 1'b1 || m_d_data !== trig || m_d_last !== 1'b0) begin
      fails++;
      $display("FAIL bp_hold: got valid %b last %b want 1 0",
               m_d_valid, m_d_last);
    end
    tests++;
    if (ovf !== 1'b1) begin
      fails++;
      $display("FAIL bp_overflow: got %b want 1", ovf);
    end
    clr = 1'b1;
    send(mk(0), 1'b0);
    clr = 1'b0;
    tests++;
    if (ovf !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clear: got %b want 0", ovf);
    end
    send(trig, 1'b1);
    clr = 1'b1;
    send(mk(0), 1'b0);
    clr = 1'b0;
    tests++;
    if (ovf !== 1'b1) begin
      fails++;
      $display("FAIL ovf_set_wins: got %b want 1", ovf);
    end
    send(mk(100), 1'b1);
    drain();
    d_ready = 1'b1;
    drain();
    tests++;
    if (got_d.size() != 1 || got_d[0].data !== trig || m_d_valid !== 1'b0)
    begin
      fails++;
      $display("FAIL bp_release: got %0d beats valid %b want 1 beat 0",
               got_d.size(), m_d_valid);
    end
    do_reset();
    en      = 1'b1;
    thr_hi  = 16'd1000;
    thr_lo  = 16'd2000;
    b       = put(mk(0), 2, 1500);
    t_ready = 1'b0;
    send(b, 1'b1);
    send(mk(0), 1'b1);
    send(b, 1'b1);
    drain();
    tests++;
    if (ovf !== 1'b1 || m_t_valid !== 1'b1 || m_t_data !== 48'd0) begin
      fails++;
      $display("FAIL ts_drop: got ovf %b valid %b ts %0d want 1 1 0",
               ovf, m_t_valid, m_t_data);
    end
    tests++;
    if (got_d.size() != 2) begin
      fails++;
      $display("FAIL ts_drop_data: got %0d beats want 2", got_d.size());
    end
    t_ready = 1'b1;
    drain();
  endtask

  task automatic test_wrap();
    logic [DW-1:0] b;
    do_reset();
    en     = 1'b1;
    thr_hi = 16'd1000;
    thr_lo = 16'd2000;
    b      = put(mk(0), 11, 1500);
    for (int i = 0; i < 15; i++) send(mk(0), 1'b1);
    send(b, 1'b1);
    send(b, 1'b1);
    drain();
    tests++;
    if (got_tn.size() != 2 || got_tn[0] !== 4'hF || got_tn[1] !== 4'h0)
    begin
      fails++;
      $display("FAIL idx_wrap: got n=%0d want ts F then 0", got_tn.size());
    end
    tests++;
    if (got_t.size() != 2 || got_t[0] !== 48'd15 || got_t[1] !== 48'd16)
    begin
      fails++;
      $display("FAIL idx_wide: got n=%0d want ts 15 then 16", got_t.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] b;
    do_reset();
    en     = 1'b1;
    thr_hi = 16'd1000;
    thr_lo = 16'd200;
    send(put(mk(0), 1, 1200), 1'b1);
    send(mk(500), 1'b1);
    send(mk(500), 1'b1);
    s_tvalid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if ({m_d_valid, m_t_valid, m_d_last, s_tready} !== 4'b0) begin
      fails++;
      $display("FAIL reset_mid: got %b want 0000",
               {m_d_valid, m_t_valid, m_d_last, s_tready});
    end
    reset = 1'b0;
    m_seg = 1'b0;
    m_idx = '0;
    clear_q();
    @(posedge clk);
    #1;
    thr_lo = 16'd2000;
    b      = put(mk(0), 6, 1500);
    send(b, 1'b1);
    drain();
    tests++;
    if (got_t.size() != 1 || got_t[0] !== 48'd0 || got_d.size() != 1) begin
      fails++;
      $display("FAIL reset_idx: got %0d ts %0d beats want ts 0, 1 beat",
               got_t.size(), got_d.size());
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    int base;
    int v;
    int h;
    int l;
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 600; k++) begin
      if (k % 60 == 0) begin
        h      = int'($urandom_range(1500, 500));
        l      = int'($urandom_range(1000, 0)) - 300;
        thr_hi = h[15:0];
        thr_lo = l[15:0];
      end
      if ($urandom_range(29, 0) == 0) en = ~en;
      base = int'($urandom_range(2000, 0)) - 400;
      for (int i = 0; i < N; i++) begin
        v = base + int'($urandom_range(100, 0)) - 50;
        d[i*SW +: SW] = v[15:0];
      end
      if ($urandom_range(7, 0) == 0)
        d = put(d, int'($urandom_range(15, 0)), 1600);
      send(d, ($urandom_range(4, 0) != 0));
    end
    drain();
    tests++;
    if (got_d.size() != exp_d.size()) begin
      fails++;
      $display("FAIL rand_count: got %0d beats want %0d",
               got_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      tests++;
      if (got_d[i].data !== exp_d[i].data
          || got_d[i].last !== exp_d[i].last) begin
        fails++;
        $display("FAIL rand_beat%0d: got last %b want %b", i,
                 got_d[i].last, exp_d[i].last);
      end
    end
    tests++;
    if (got_t.size() != exp_t.size()) begin
      fails++;
      $display("FAIL rand_ts_count: got %0d want %0d",
               got_t.size(), exp_t.size());
    end
    for (int i = 0; i < exp_t.size() && i < got_t.size(); i++) begin
      tests++;
      if (got_t[i] !== exp_t[i]) begin
        fails++;
        $display("FAIL rand_ts%0d: got %0d want %0d", i,
                 got_t[i], exp_t[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_single();
    test_enable_drop();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
